// File: rtl/dram_pkg.sv
// Shared types and default DDR timing for the DRAM command scheduler.
// Timing values are in controller clock cycles.
package dram_pkg;

    typedef enum logic [1:0] {
        CMD_PRE = 2'd0,
        CMD_ACT = 2'd1,
        CMD_RD  = 2'd2,
        CMD_WR  = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_IFETCH = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_PRE,
        ST_ISSUE_ACT,
        ST_ISSUE_COL,
        ST_DATA_WAIT
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [14:0] row;
        logic [7:0]  col;
    } req_t;

    localparam int unsigned DEF_T_RP    = 24;
    localparam int unsigned DEF_T_RCD   = 24;
    localparam int unsigned DEF_T_CAS   = 24;
    localparam int unsigned DEF_T_CWL   = 20;
    localparam int unsigned DEF_T_BURST = 4;
    localparam int unsigned DEF_T_RAS   = 52;
    localparam int unsigned DEF_T_RTP   = 12;
    localparam int unsigned DEF_T_WR    = 20;

    localparam logic [7:0] ELAPSED_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ELAPSED_MAX) ? v : v + 8'd1;
    endfunction

    function automatic logic elapsed_ge(input logic [7:0] elapsed, input int unsigned t);
        return {24'd0, elapsed} >= t;
    endfunction

endpackage

// File: rtl/dram_bank_tracker.sv
// One bank's open-row state plus saturating elapsed-cycle counters since
// its last PRE, ACT, RD and WR.
module dram_bank_tracker
    import dram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_hit,
    input  logic [1:0]  cmd_type,
    input  logic [14:0] cmd_row,
    output logic        is_open,
    output logic [14:0] open_row,
    output logic [7:0]  since_pre,
    output logic [7:0]  since_act,
    output logic [7:0]  since_rd,
    output logic [7:0]  since_wr
);

    logic hit_pre, hit_act, hit_rd, hit_wr;

    assign hit_pre = cmd_hit && (cmd_type == CMD_PRE);
    assign hit_act = cmd_hit && (cmd_type == CMD_ACT);
    assign hit_rd  = cmd_hit && (cmd_type == CMD_RD);
    assign hit_wr  = cmd_hit && (cmd_type == CMD_WR);

    // A counter reads 1 in the cycle after its command commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_open   <= 1'b0;
            open_row  <= '0;
            since_pre <= ELAPSED_MAX;
            since_act <= ELAPSED_MAX;
            since_rd  <= ELAPSED_MAX;
            since_wr  <= ELAPSED_MAX;
        end else begin
            since_pre <= hit_pre ? 8'd1 : sat_inc(since_pre);
            since_act <= hit_act ? 8'd1 : sat_inc(since_act);
            since_rd  <= hit_rd  ? 8'd1 : sat_inc(since_rd);
            since_wr  <= hit_wr  ? 8'd1 : sat_inc(since_wr);
            if (hit_pre) begin
                is_open <= 1'b0;
            end
            if (hit_act) begin
                is_open  <= 1'b1;
                open_row <= cmd_row;
            end
        end
    end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Serialized open-page DRAM command scheduler: accepts one request at a time
// and issues timing-legal PRE/ACT/RD/WR for it across 16 banks.
module dram_cmd_scheduler
    import dram_pkg::*;
#(
    parameter int unsigned T_RP    = DEF_T_RP,
    parameter int unsigned T_RCD   = DEF_T_RCD,
    parameter int unsigned T_CAS   = DEF_T_CAS,
    parameter int unsigned T_CWL   = DEF_T_CWL,
    parameter int unsigned T_BURST = DEF_T_BURST,
    parameter int unsigned T_RAS   = DEF_T_RAS,
    parameter int unsigned T_RTP   = DEF_T_RTP,
    parameter int unsigned T_WR    = DEF_T_WR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_bg,
    input  logic [1:0]  req_bank,
    input  logic [14:0] req_row,
    input  logic [7:0]  req_col,
    output logic        cmd_valid,
    output logic [1:0]  cmd_type,
    output logic [1:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [14:0] cmd_row,
    output logic [7:0]  cmd_col,
    output logic        req_done,
    output logic        busy
);

    localparam int unsigned WR_TO_PRE = T_CWL + T_BURST + T_WR;
    // The issue cycle itself counts toward the data wait.
    localparam int unsigned RD_WAIT   = T_CAS + T_BURST - 1;
    localparam int unsigned WR_WAIT   = T_CWL + T_BURST - 1;

    state_e     state_q, state_d;
    req_t       req_q, req_d;
    logic [7:0] cnt_q, cnt_d;
    logic       issue;
    cmd_e       issue_type;
    logic       done_d;
    logic [3:0] in_idx, cur_idx;

    logic        bank_open [16];
    logic [14:0] bank_row  [16];
    logic [7:0]  since_pre [16];
    logic [7:0]  since_act [16];
    logic [7:0]  since_rd  [16];
    logic [7:0]  since_wr  [16];

    assign in_idx  = {req_bg, req_bank};
    assign cur_idx = {req_q.bg, req_q.bank};

    for (genvar i = 0; i < 16; i++) begin : g_bank
        dram_bank_tracker u_trk (
            .clk       (clk),
            .rst       (rst),
            .cmd_hit   (issue && (cur_idx == 4'(i))),
            .cmd_type  (issue_type),
            .cmd_row   (req_q.row),
            .is_open   (bank_open[i]),
            .open_row  (bank_row[i]),
            .since_pre (since_pre[i]),
            .since_act (since_act[i]),
            .since_rd  (since_rd[i]),
            .since_wr  (since_wr[i])
        );
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = ~req_ready;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        issue      = 1'b0;
        issue_type = CMD_PRE;
        done_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d = '{op: op_e'(req_op), bg: req_bg, bank: req_bank,
                              row: req_row, col: req_col};
                    if (op_e'(req_op) == OP_RSVD) begin
                        state_d = ST_DATA_WAIT;
                        cnt_d   = 8'd1;
                    end else if (!bank_open[in_idx]) begin
                        state_d = ST_ISSUE_ACT;
                    end else if (bank_row[in_idx] == req_row) begin
                        state_d = ST_ISSUE_COL;
                    end else begin
                        state_d = ST_ISSUE_PRE;
                    end
                end
            end
            ST_ISSUE_PRE: begin
                if (elapsed_ge(since_act[cur_idx], T_RAS) &&
                    elapsed_ge(since_rd[cur_idx], T_RTP) &&
                    elapsed_ge(since_wr[cur_idx], WR_TO_PRE)) begin
                    issue      = 1'b1;
                    issue_type = CMD_PRE;
                    state_d    = ST_ISSUE_ACT;
                end
            end
            ST_ISSUE_ACT: begin
                // A never-precharged or reset bank holds 255 here, so it passes at once.
                if (elapsed_ge(since_pre[cur_idx], T_RP)) begin
                    issue      = 1'b1;
                    issue_type = CMD_ACT;
                    state_d    = ST_ISSUE_COL;
                end
            end
            ST_ISSUE_COL: begin
                if (elapsed_ge(since_act[cur_idx], T_RCD)) begin
                    issue   = 1'b1;
                    state_d = ST_DATA_WAIT;
                    if (req_q.op == OP_WRITE) begin
                        issue_type = CMD_WR;
                        cnt_d      = 8'(WR_WAIT);
                    end else begin
                        issue_type = CMD_RD;
                        cnt_d      = 8'(RD_WAIT);
                    end
                end
            end
            ST_DATA_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            cnt_q     <= '0;
            cmd_valid <= 1'b0;
            cmd_type  <= '0;
            cmd_bg    <= '0;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            req_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            cmd_valid <= issue;
            req_done  <= done_d;
            if (issue) begin
                cmd_type <= issue_type;
                cmd_bg   <= req_q.bg;
                cmd_bank <= req_q.bank;
                cmd_row  <= req_q.row;
                cmd_col  <= req_q.col;
            end else begin
                cmd_type <= '0;
                cmd_bg   <= '0;
                cmd_bank <= '0;
                cmd_row  <= '0;
                cmd_col  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: table of requests with expected command
// timing, a scoreboard of timestamped events, plus reset and backpressure sequences.
module tb_dram_cmd_scheduler;

    localparam int W = 46;  // {cycle[15:0], kind[2:0], bg, bank, row, col}

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_bg;
    logic [1:0]  req_bank;
    logic [14:0] req_row;
    logic [7:0]  req_col;
    logic        cmd_valid;
    logic [1:0]  cmd_type;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [14:0] cmd_row;
    logic [7:0]  cmd_col;
    logic        req_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [14:0] row;
        logic [7:0]  col;
        int          pre_t;
        int          act_t;
        int          col_t;
        int          done_t;
    } vec_t;

    vec_t vecs[11];

    dram_cmd_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_bg    (req_bg),
        .req_bank  (req_bank),
        .req_row   (req_row),
        .req_col   (req_col),
        .cmd_valid (cmd_valid),
        .cmd_type  (cmd_type),
        .cmd_bg    (cmd_bg),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .req_done  (req_done),
        .busy      (busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Kinds 0..3 are PRE/ACT/RD/WR, 4 is req_done; irrelevant fields are masked.
    function automatic logic [W-1:0] ev(input int c, input logic [2:0] kind,
                                        input logic [1:0] bg, input logic [1:0] bank,
                                        input logic [14:0] row, input logic [7:0] col);
        logic [1:0]  b;
        logic [1:0]  bk;
        logic [14:0] r;
        logic [7:0]  k;
        b  = (kind == 3'd4) ? 2'd0 : bg;
        bk = (kind == 3'd4) ? 2'd0 : bank;
        r  = (kind == 3'd1) ? row : 15'd0;
        k  = (kind == 3'd2 || kind == 3'd3) ? col : 8'd0;
        return {16'(c), kind, b, bk, r, k};
    endfunction

    task automatic check_event(input logic [W-1:0] obs);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %h, nothing expected", obs);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL event: got %h want %h", obs, e);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (cmd_valid === 1'b1)
            check_event(ev(cyc, {1'b0, cmd_type}, cmd_bg, cmd_bank, cmd_row, cmd_col));
        if (req_done === 1'b1) begin
            done_seen++;
            check_event(ev(cyc, 3'd4, 2'd0, 2'd0, 15'd0, 8'd0));
        end
    end

    // ---------------- driver tasks ----------------
    // Returns the cycle whose closing edge accepted the request.
    task automatic send(input logic [1:0] op, input logic [1:0] bg, input logic [1:0] bank,
                        input logic [14:0] row, input logic [7:0] col, output int a);
        int waited;
        waited = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: req_ready=%b want 1", req_ready);
            a = -1;
        end else begin
            req_valid = 1'b1;
            req_op    = op;
            req_bg    = bg;
            req_bank  = bank;
            req_row   = row;
            req_col   = col;
            a = cyc;
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    // Commands committed in cycle t show on the registered bus in cycle t+1.
    task automatic push_expect(input int a, input vec_t v);
        if (a >= 0) begin
            if (v.pre_t >= 0)
                exp_q.push_back(ev(a + v.pre_t + 1, 3'd0, v.bg, v.bank, v.row, v.col));
            if (v.act_t >= 0)
                exp_q.push_back(ev(a + v.act_t + 1, 3'd1, v.bg, v.bank, v.row, v.col));
            if (v.col_t >= 0)
                exp_q.push_back(ev(a + v.col_t + 1, (v.op == 2'd1) ? 3'd3 : 3'd2,
                                   v.bg, v.bank, v.row, v.col));
            exp_q.push_back(ev(a + v.done_t, 3'd4, 2'd0, 2'd0, 15'd0, 8'd0));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int a;
        send(v.op, v.bg, v.bank, v.row, v.col, a);
        push_expect(a, v);
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        check_val(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        check_val({name, "_ready_busy"}, {30'd0, req_ready, busy}, 32'h2);
        check_val({name, "_valid_done"}, {30'd0, cmd_valid, req_done}, 32'h0);
        check_val({name, "_fields"}, {3'd0, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col}, 32'h0);
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] bg, input logic [1:0] bank,
                                input logic [14:0] row, input logic [7:0] col,
                                input int pre_t, input int act_t, input int col_t, input int done_t);
        vec_t v;
        v.op = op; v.bg = bg; v.bank = bank; v.row = row; v.col = col;
        v.pre_t = pre_t; v.act_t = act_t; v.col_t = col_t; v.done_t = done_t;
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int a;
        int accepts;
        int done_base;
        vec_t v;

        rst = 1'b1;
        req_valid = 1'b0;
        req_op = '0; req_bg = '0; req_bank = '0; req_row = '0; req_col = '0;

        // Times are relative to the acceptance cycle; -1 means no such command.
        vecs[0]  = mk(2'd0, 2'd1, 2'd2, 15'h1A3, 8'h10, -1,  1, 25, 53);  // empty bank read
        vecs[1]  = mk(2'd0, 2'd1, 2'd2, 15'h1A3, 8'h11, -1, -1,  1, 29);  // row hit
        vecs[2]  = mk(2'd0, 2'd1, 2'd2, 15'h1A4, 8'h12,  1, 25, 49, 77);  // row miss
        vecs[3]  = mk(2'd1, 2'd0, 2'd0, 15'h0005, 8'h03, -1, 1, 25, 49);  // write, closed bank
        vecs[4]  = mk(2'd0, 2'd0, 2'd0, 15'h0006, 8'h04, 20, 44, 68, 96); // write recovery gate
        vecs[5]  = mk(2'd3, 2'd3, 2'd1, 15'h7FFF, 8'hFF, -1, -1, -1, 2);  // reserved op
        vecs[6]  = mk(2'd2, 2'd3, 2'd3, 15'h0007, 8'h20, -1, 1, 25, 53);  // ifetch as read
        vecs[7]  = mk(2'd1, 2'd2, 2'd3, 15'h0010, 8'h30, -1, 1, 25, 49);  // write, ACT early
        vecs[8]  = mk(2'd1, 2'd2, 2'd3, 15'h0011, 8'h31, 20, 44, 68, 92); // tRAS/tWR gated miss
        vecs[9]  = mk(2'd0, 2'd1, 2'd2, 15'h1A4, 8'h40, -1, -1, 1, 29);   // other bank still open
        vecs[10] = mk(2'd0, 2'd3, 2'd3, 15'h0007, 8'h7F, -1, -1, 1, 29);

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Random-column write hits then a read hit on the open row.
        for (int i = 0; i < 3; i++) begin
            v = mk(2'd1, 2'd1, 2'd2, 15'h1A4, 8'($urandom_range(0, 255)), -1, -1, 1, 25);
            run_vec(v);
        end
        run_vec(mk(2'd0, 2'd1, 2'd2, 15'h1A4, 8'($urandom_range(0, 255)), -1, -1, 1, 29));
        drain("drain_table");

        // Reset between ACT and RD: no RD, no done, and the bank is closed afterwards.
        send(2'd0, 2'd1, 2'd1, 15'h0055, 8'h21, a);
        if (a >= 0) exp_q.push_back(ev(a + 2, 3'd1, 2'd1, 2'd1, 15'h0055, 8'h21));
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain("drain_before_reset");
        run_vec(mk(2'd0, 2'd1, 2'd1, 15'h0066, 8'h22, -1, 1, 25, 53));
        drain("drain_after_reset");

        // Backpressure: req_valid stays high with junk fields while busy.
        accepts = 0;
        done_base = done_seen;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            req_valid = 1'b1;
            req_bg    = 2'($urandom_range(0, 3));
            req_bank  = 2'($urandom_range(0, 3));
            req_row   = 15'($urandom_range(0, 32767));
            req_col   = 8'($urandom_range(0, 255));
            if (req_ready === 1'b1) begin
                req_op = 2'd3;
                exp_q.push_back(ev(cyc + 2, 3'd4, 2'd0, 2'd0, 15'd0, 8'd0));
                accepts++;
            end else begin
                req_op = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        drain("drain_backpressure");
        check_val("bp_accepts", 32'(accepts), 32'd20);
        check_val("bp_accept_vs_done", 32'(accepts), 32'(done_seen - done_base));

        repeat (5) @(negedge clk);
        check_idle_outputs("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
